// File: rtl/shift_div_pkg.sv
// shift_div_pkg -- shared constants for the shift-subtract divider.
//   S_IDLE/S_RUN/S_DONE : FSM state encodings
//   DEF_WIDTH           : default operand width
//   DBZ_FILL            : fill bit for the divide-by-zero quotient (all ones)
package shift_div_pkg;
   localparam int         DEF_WIDTH = 8;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic       DBZ_FILL  = 1'b1;
endpackage

// File: rtl/shift_div_step.sv
// shift_div_step -- one combinational restoring-division step.
//   rem_i      : current partial remainder (always < divisor, so WIDTH bits suffice)
//   quot_msb_i : next dividend bit shifted into the remainder
//   b_i        : divisor
//   rem_o      : next partial remainder
//   qbit_o     : quotient bit produced by this step
module shift_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             quot_msb_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem_i, quot_msb_i};
      trial   = shifted - {1'b0, b_i};
      // MSB clear means shifted >= b; the kept value is then < b and fits WIDTH bits
      qbit_o  = ~trial[WIDTH];
      rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/shift_div8.sv
// shift_div8 -- sequential restoring unsigned divider, one quotient bit per
// falling clock edge, with start/busy/done handshake.
//   clk, rst_n      : clock (falling-edge state updates), async active-low reset
//   start, a, b     : launch request, dividend, divisor (latched on accept)
//   busy            : divide in progress
//   done            : result valid and held
//   div_by_zero     : latched divisor was zero (valid with done)
//   q, r            : registered quotient and remainder
module shift_div8
   import shift_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic [WIDTH-1:0] quot_q,  quot_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic [WIDTH-1:0] r_q,     r_d;
   logic             dbz_q,   dbz_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] quot_next;

   shift_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i      (rem_q),
      .quot_msb_i (quot_q[WIDTH-1]),
      .b_i        (b_q),
      .rem_o      (step_rem),
      .qbit_o     (step_qbit)
   );

   // dividend bits leave the top of quot_q as quotient bits enter the bottom
   assign quot_next = {quot_q[WIDTH-2:0], step_qbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               b_d    = b;
               quot_d = a;
               rem_d  = '0;
               cnt_d  = '0;
               if (b == '0) begin
                  // zero divisor short-circuits straight to a held result
                  state_d = S_DONE;
                  q_d     = {WIDTH{DBZ_FILL}};
                  r_d     = a;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  dbz_d   = 1'b0;
               end
            end
         end
         S_RUN: begin
            rem_d  = step_rem;
            quot_d = quot_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               q_d     = quot_next;
               r_d     = step_rem;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q & done;
   assign q           = q_q;
   assign r           = r_q;
endmodule

// File: tb/tb_shift_div8.sv
module tb_shift_div8;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, div_by_zero;
   logic [7:0] q, r;

   int checks   = 0;
   int failures = 0;

   shift_div8 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .q(q), .r(r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Launch one divide (inputs changed at posedge, away from the falling edge)
   // and wait for done; returns result, latency in falling edges and busy count.
   task automatic run_div(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] oq, output logic [7:0] orr,
                          output logic odbz, output int lat, output int nbusy);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk);              // accepting falling edge (edge 0) has passed
      start = 1'b0;
      lat = 0; nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         @(posedge clk);
         lat++;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout a=%0d b=%0d", ia, ib);
      end
      oq = q; orr = r; odbz = div_by_zero;
   endtask

   vec_t vecs[11];

   initial begin
      logic [7:0] rq, rr;
      logic       rd;
      int         lat, nb;

      vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[2]  = '{8'd5,   8'd10,  8'd0,   8'd5,   1'b0};
      vecs[3]  = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
      vecs[4]  = '{8'd77,  8'd0,   8'hFF,  8'd77,  1'b1};
      vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[6]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[7]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
      vecs[8]  = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};
      vecs[9]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
      vecs[10] = '{8'd100, 8'd9,   8'd11,  8'd1,   1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", div_by_zero, 0);
      chk("reset_q", q, 0);
      chk("reset_r", r, 0);
      rst_n = 1'b1;
      @(posedge clk);
      chk("idle_done", done, 0);

      // table-driven vectors
      for (int i = 0; i < 11; i++) begin
         run_div(vecs[i].a, vecs[i].b, rq, rr, rd, lat, nb);
         chk($sformatf("v%0d_q", i), rq, vecs[i].q);
         chk($sformatf("v%0d_r", i), rr, vecs[i].r);
         chk($sformatf("v%0d_dbz", i), rd, vecs[i].dbz);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].dbz ? 0 : 8);
         chk($sformatf("v%0d_busy", i), nb, vecs[i].dbz ? 0 : 8);
      end

      // start/operand changes while busy are ignored; q holds old result during RUN
      run_div(8'd200, 8'd7, rq, rr, rd, lat, nb);
      a = 8'd100; b = 8'd9; start = 1'b1;
      @(posedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      chk("hold_q_in_run", q, 28);
      a = 8'd1; b = 8'd1; start = 1'b1;
      @(posedge clk); start = 1'b0; a = 8'd3; b = 8'd2;
      begin
         int n = 0;
         while (!done && n < 20) begin @(posedge clk); n++; end
         chk("ign_done_edge", n, 4);
      end
      chk("ign_q", q, 11);
      chk("ign_r", r, 1);

      // asynchronous reset mid-divide
      a = 8'd200; b = 8'd7; start = 1'b1;
      @(posedge clk); start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_q", q, 0);
      chk("rst_mid_r", r, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      @(posedge clk); rst_n = 1'b1;
      @(posedge clk);
      run_div(8'd200, 8'd7, rq, rr, rd, lat, nb);
      chk("rst_redo_q", rq, 28);
      chk("rst_redo_r", rr, 4);

      // start held high: restart from DONE without passing through IDLE
      a = 8'd250; b = 8'd16; start = 1'b1;
      begin
         int n = 0;
         @(posedge clk);
         while (!done && n < 20) begin @(posedge clk); n++; end
      end
      chk("b2b_q1", q, 15);
      chk("b2b_r1", r, 10);
      a = 8'd13; b = 8'd13;
      @(posedge clk);
      chk("b2b_restart_busy", busy, 1);
      chk("b2b_restart_done", done, 0);
      chk("b2b_hold_q", q, 15);
      start = 1'b0;
      begin
         int n = 0;
         while (!done && n < 20) begin @(posedge clk); n++; end
      end
      chk("b2b_q2", q, 1);
      chk("b2b_r2", r, 0);

      // randomized sweep against arithmetic reference (zero divisor included)
      for (int i = 0; i < 400; i++) begin
         logic [7:0] ta, tb;
         ta = 8'($urandom_range(0, 255));
         tb = (i % 40 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         run_div(ta, tb, rq, rr, rd, lat, nb);
         chk($sformatf("sw_q %0d/%0d", ta, tb), rq, (tb == 0) ? 8'hFF : ta / tb);
         chk($sformatf("sw_r %0d/%0d", ta, tb), rr, (tb == 0) ? ta : ta % tb);
         chk($sformatf("sw_dbz %0d/%0d", ta, tb), rd, (tb == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
